hssi_mbox_responder: RTL
========================

Name: hssi_mbox_responder

Overview:
- Target-side end of the HE-HSSI traffic-controller mailbox.
- Accepts host CSR writes to four mailbox registers (CMD, ADDRESS, RDDATA, WRDATA) and executes one read or write per command on the traffic-controller/MAC-statistics register bus.
- Reports completion, busy and error status back through the CMD register.
- Sits between the HE-HSSI CSR decoder and the traffic controller / MAC stats Avalon-MM port.

Parameters:
- TGT_AW, 16, target bus byte-address width; ADDRESS[TGT_AW-1:0] is driven, upper bits are ignored.
- TIMEOUT_CYC, 256, cycles allowed per target access before abort; legal range 2..65535.
- ERR_RDATA, 32'hFFFF_FFFF, value loaded into RDDATA on timeout or illegal command.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- csr_addr  in  4  byte offset: 0x0 CMD, 0x4 ADDRESS, 0x8 RDDATA, 0xC WRDATA; other offsets read 0 and ignore writes.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data.
- csr_readdatavalid  out  1  one-cycle pulse, one cycle after csr_read.
- tgt_address  out  TGT_AW  target byte address.
- tgt_read  out  1  target read request.
- tgt_write  out  1  target write request.
- tgt_writedata  out  32  target write data.
- tgt_waitrequest  in  1  target stall.
- tgt_readdata  in  32  target read data.
- tgt_readdatavalid  in  1  target read data valid.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All registers = 0; state = IDLE.
  - tgt_read=0, tgt_write=0, csr_readdatavalid=0, csr_readdata=0.
  - A reset mid-transaction drops the request immediately; nothing is retried.
- CMD readback: {27'b0, err[4], busy[3], ack[2], cmd[1:0]}.
- CSR writes:
  - Writes to ADDRESS and WRDATA are accepted only when busy=0; otherwise ignored.
  - RDDATA is read-only.
- CMD write decodes csr_writedata[1:0]; it is ignored entirely if busy=1.
  - 0 (NOOP): clears ack and err; no target access.
  - 1 (RD), 2 (WR): clears ack/err, sets busy, cmd field = value, goes to RD_REQ or WR_REQ next cycle.
  - 3 (illegal): ack=1, err=1, RDDATA=ERR_RDATA, busy stays 0; no target access.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE -> RD_REQ/WR_REQ: CMD write accepted at edge N; tgt_read or tgt_write is high from cycle N+1.
  - RD_REQ:
    - tgt_read=1 and tgt_address held until sampled with tgt_waitrequest=0, then tgt_read drops and state -> RD_WAIT.
    - If tgt_readdatavalid arrives in that same cycle, data is captured and state goes straight to IDLE.
  - RD_WAIT: on tgt_readdatavalid, RDDATA <= tgt_readdata, ack=1, busy=0, cmd=0, state -> IDLE.
  - WR_REQ: tgt_write=1 with address/data held until tgt_waitrequest=0; then ack=1, busy=0, cmd=0, state -> IDLE the following cycle.
- Timeout:
  - A 16-bit counter clears on entry to RD_REQ/WR_REQ and increments each cycle while not in IDLE.
  - At count == TIMEOUT_CYC-1 without completion: deassert request, err=1, ack=1, busy=0, cmd=0, RDDATA=ERR_RDATA (reads only), state -> IDLE.
  - A tgt_readdatavalid arriving in IDLE is ignored.
- CSR read:
  - Registered; csr_readdata is valid with csr_readdatavalid exactly one cycle after csr_read.
  - Returns register values as of the edge at which csr_read is sampled.
  - If csr_read and csr_write hit the same register in the same cycle, the pre-write value is returned.
- Completion vs CMD write in the same cycle: completion updates take effect and the CMD write is ignored (busy was still 1).
- A RD while the previous ack=1 is legal; ack and err are cleared by the new command.

Test Plan:
- Read stats: ADDRESS=0x3008, CMD=1; target readdata=0x20 after 3 waitrequest cycles and 2 latency cycles -> RDDATA=0x0000_0020; CMD readback=0x4.
- Write: ADDRESS=0x30, WRDATA=0x0000_0042, CMD=2 with waitrequest=0 -> single tgt_write pulse at 0x30 carrying 0x42, one cycle long; CMD readback=0x4.
- Busy lockout: during a stalled RD, write ADDRESS=0x7000 and CMD=2 -> both ignored; tgt_address stays 0x3008; CMD readback=0x9 until completion.
- Timeout: TIMEOUT_CYC=16, waitrequest held high -> tgt_read drops after 16 cycles; RDDATA=0xFFFF_FFFF; CMD readback=0x14; later stray readdatavalid leaves RDDATA unchanged.
- Illegal/NOOP: CMD=3 -> readback 0x14 with no target access; then CMD=0 -> readback 0x0.
- Reset mid-read: rst_n low for 1 cycle during RD_WAIT -> all outputs 0 next cycle; CMD readback 0x0; next RD to 0x3010 completes normally.

Source files
------------

// File: rtl/hssi_mbox_responder.sv
// Target-side end of the HE-HSSI traffic-controller mailbox.
// The host writes ADDRESS/WRDATA, then CMD; the block runs one read or write on the
// target register bus and reports ack/busy/err back through CMD.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   csr_*               host CSR port (0x0 CMD, 0x4 ADDRESS, 0x8 RDDATA, 0xC WRDATA)
//   tgt_*               Avalon-MM style master towards traffic controller / MAC stats
module hssi_mbox_responder #(
  parameter int unsigned TGT_AW      = 16,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        csr_addr,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              csr_readdatavalid,
  output logic [TGT_AW-1:0] tgt_address,
  output logic              tgt_read,
  output logic              tgt_write,
  output logic [31:0]       tgt_writedata,
  input  logic              tgt_waitrequest,
  input  logic [31:0]       tgt_readdata,
  input  logic              tgt_readdatavalid
);

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [1:0]  cmd_q;
  logic        ack_q, busy_q, err_q;
  logic [31:0] addr_q, rddata_q, wrdata_q;
  logic [15:0] cnt_q;
  logic        tgt_read_q, tgt_write_q;
  logic [31:0] csr_rdata_d;
  logic        timeout;

  assign timeout       = (cnt_q == TimeoutLast);
  assign tgt_address   = addr_q[TGT_AW-1:0];
  assign tgt_writedata = wrdata_q;
  assign tgt_read      = tgt_read_q;
  assign tgt_write     = tgt_write_q;

  // Readback uses pre-edge register values, so a same-cycle write returns the old value.
  always_comb begin
    csr_rdata_d = '0;
    case (csr_addr)
      4'h0:    csr_rdata_d = {27'b0, err_q, busy_q, ack_q, cmd_q};
      4'h4:    csr_rdata_d = addr_q;
      4'h8:    csr_rdata_d = rddata_q;
      4'hC:    csr_rdata_d = wrdata_q;
      default: csr_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      cmd_q             <= '0;
      ack_q             <= 1'b0;
      busy_q            <= 1'b0;
      err_q             <= 1'b0;
      addr_q            <= '0;
      rddata_q          <= '0;
      wrdata_q          <= '0;
      cnt_q             <= '0;
      tgt_read_q        <= 1'b0;
      tgt_write_q       <= 1'b0;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) csr_readdata <= csr_rdata_d;

      // busy_q is set exactly while the FSM is away from StIdle, so host writes and
      // FSM updates below never touch the same register in one cycle.
      if (csr_write && !busy_q) begin
        case (csr_addr)
          4'h4: addr_q   <= csr_writedata;
          4'hC: wrdata_q <= csr_writedata;
          4'h0: begin
            case (csr_writedata[1:0])
              2'd0: begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
              end
              2'd1, 2'd2: begin
                ack_q  <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
                cmd_q  <= csr_writedata[1:0];
                cnt_q  <= '0;
                if (csr_writedata[1:0] == 2'd1) begin
                  state_q    <= StRdReq;
                  tgt_read_q <= 1'b1;
                end else begin
                  state_q     <= StWrReq;
                  tgt_write_q <= 1'b1;
                end
              end
              default: begin
                ack_q    <= 1'b1;
                err_q    <= 1'b1;
                rddata_q <= ERR_RDATA;
              end
            endcase
          end
          default: ;
        endcase
      end

      if (state_q != StIdle) cnt_q <= cnt_q + 16'd1;

      case (state_q)
        StRdReq: begin
          if (!tgt_waitrequest && tgt_readdatavalid) begin
            // Zero-latency target: accept and data in the same cycle.
            tgt_read_q <= 1'b0;
            rddata_q   <= tgt_readdata;
            ack_q      <= 1'b1;
            busy_q     <= 1'b0;
            cmd_q      <= '0;
            state_q    <= StIdle;
          end else if (timeout) begin
            tgt_read_q <= 1'b0;
            rddata_q   <= ERR_RDATA;
            err_q      <= 1'b1;
            ack_q      <= 1'b1;
            busy_q     <= 1'b0;
            cmd_q      <= '0;
            state_q    <= StIdle;
          end else if (!tgt_waitrequest) begin
            tgt_read_q <= 1'b0;
            state_q    <= StRdWait;
          end
        end
        StRdWait: begin
          if (tgt_readdatavalid) begin
            rddata_q <= tgt_readdata;
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            cmd_q    <= '0;
            state_q  <= StIdle;
          end else if (timeout) begin
            rddata_q <= ERR_RDATA;
            err_q    <= 1'b1;
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            cmd_q    <= '0;
            state_q  <= StIdle;
          end
        end
        StWrReq: begin
          if (!tgt_waitrequest) begin
            tgt_write_q <= 1'b0;
            ack_q       <= 1'b1;
            busy_q      <= 1'b0;
            cmd_q       <= '0;
            state_q     <= StIdle;
          end else if (timeout) begin
            tgt_write_q <= 1'b0;
            err_q       <= 1'b1;
            ack_q       <= 1'b1;
            busy_q      <= 1'b0;
            cmd_q       <= '0;
            state_q     <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
